eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter_if.sv | 28 ++
 rtl/eth_tx_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter_if
// Brief    : AXI-Stream bundle with destination MAC / ethertype sideband.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_tx_arbiter_if #(
    parameter int AXIS_BYTES = 4
);
    logic                      tvalid;
    logic                      tready;
    logic                      tlast;
    logic [AXIS_BYTES-1:0]     tkeep;
    logic [8*AXIS_BYTES-1:0]   tdata;
    logic [47:0]               dst_mac;
    logic [15:0]               ethertype;

    modport master (
        output tvalid, tlast, tkeep, tdata, dst_mac, ethertype,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tkeep, tdata, dst_mac, ethertype,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Brief    : Two-requester round-robin packet arbiter in front of eth_framer.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
    parameter int AXIS_BYTES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    eth_tx_arbiter_if.slave        axis_i0,
    eth_tx_arbiter_if.slave        axis_i1,
    eth_tx_arbiter_if.master       axis_o,
    output logic [CNT_WIDTH-1:0]   pkt_count_0,
    output logic [CNT_WIDTH-1:0]   pkt_count_1
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   ptr_q, ptr_d;
    logic [47:0]            dst_mac_q, dst_mac_d;
    logic [15:0]            ethertype_q, ethertype_d;
    logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]   cnt1_q, cnt1_d;

    logic                   w_out_valid;
    logic                   w_out_last;
    logic [AXIS_BYTES-1:0]  w_out_keep;
    logic [8*AXIS_BYTES-1:0] w_out_data;
    logic                   w_last_hs;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_ARB;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b0;
            dst_mac_q   <= 48'h0;
            ethertype_q <= 16'h0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            dst_mac_q   <= dst_mac_d;
            ethertype_q <= ethertype_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        dst_mac_d      = dst_mac_q;
        ethertype_d    = ethertype_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        axis_i0.tready = 1'b0;
        axis_i1.tready = 1'b0;
        w_out_valid    = 1'b0;
        w_out_last     = 1'b0;
        w_last_hs      = 1'b0;
        w_out_keep     = grant_q ? axis_i1.tkeep : axis_i0.tkeep;
        w_out_data     = grant_q ? axis_i1.tdata : axis_i0.tdata;

        case (state_q)
            ST_ARB: begin
                if (axis_i0.tvalid || axis_i1.tvalid) begin
                    // Pointer only breaks ties; a lone requester always wins.
                    if (axis_i0.tvalid && axis_i1.tvalid) begin
                        grant_d = ptr_q;
                    end else begin
                        grant_d = axis_i1.tvalid;
                    end
                    dst_mac_d   = grant_d ? axis_i1.dst_mac   : axis_i0.dst_mac;
                    ethertype_d = grant_d ? axis_i1.ethertype : axis_i0.ethertype;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (grant_q) begin
                    w_out_valid    = axis_i1.tvalid;
                    w_out_last     = axis_i1.tlast;
                    axis_i1.tready = axis_o.tready;
                end else begin
                    w_out_valid    = axis_i0.tvalid;
                    w_out_last     = axis_i0.tlast;
                    axis_i0.tready = axis_o.tready;
                end
                w_last_hs = w_out_valid && axis_o.tready && w_out_last;
                if (w_last_hs) begin
                    state_d = ST_ARB;
                    ptr_d   = ~grant_q;
                    if (grant_q) begin
                        cnt1_d = cnt1_q + CNT_WIDTH'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign axis_o.tvalid    = w_out_valid;
    assign axis_o.tlast     = w_out_last;
    assign axis_o.tkeep     = w_out_keep;
    assign axis_o.tdata     = w_out_data;
    assign axis_o.dst_mac   = dst_mac_q;
    assign axis_o.ethertype = ethertype_q;
    assign pkt_count_0      = cnt0_q;
    assign pkt_count_1      = cnt1_q;

endmodule
`default_nettype wire
